// File: rtl/rx_frame_buffer.sv
// Collects received words into a frame and hands out a stable snapshot.
// A frame closes on the terminator word or when DEPTH words have been stored.
module rx_frame_buffer #(
    parameter int                    DATA_SIZE      = 8,
    parameter int                    ADDR_SPACE_EXP = 5,
    parameter logic [DATA_SIZE-1:0]  TERMINATOR     = DATA_SIZE'('h0D),
    parameter int                    USE_TERMINATOR = 1
) (
    input  logic                                         clk_100MHz,
    input  logic                                         reset,
    input  logic                                         write_to_fifo,
    input  logic [DATA_SIZE-1:0]                         write_data_in,
    input  logic                                         clear,
    input  logic                                         frame_ack,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]     frame_data,
    output logic [ADDR_SPACE_EXP:0]                      frame_len,
    output logic                                         frame_valid,
    output logic                                         overflow,
    output logic [ADDR_SPACE_EXP:0]                      fill_count,
    output logic                                         empty,
    output logic                                         full
);

    localparam int DEPTH = 2**ADDR_SPACE_EXP;
    localparam int CW    = ADDR_SPACE_EXP + 1;
    localparam int FW    = DATA_SIZE * DEPTH;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t                     r_state;
    logic [DATA_SIZE-1:0]       r_mem [DEPTH];
    logic [ADDR_SPACE_EXP-1:0]  r_wr_ptr;
    logic [CW-1:0]              r_fill;

    logic                       w_is_term;
    logic                       w_accept;
    logic                       w_auto_close;
    logic                       w_close;
    logic [CW-1:0]              w_len;
    logic [FW-1:0]              w_snap;

    assign w_is_term    = (USE_TERMINATOR != 0) && write_to_fifo && (write_data_in == TERMINATOR);
    assign w_accept     = write_to_fifo && !w_is_term;
    assign w_auto_close = w_accept && (r_fill == CW'(DEPTH - 1));
    assign w_close      = w_auto_close || (w_is_term && (r_fill != '0));
    assign w_len        = w_auto_close ? CW'(DEPTH) : r_fill;

    // On auto-close the last word is still on the input bus, so take it from there.
    always_comb begin
        w_snap = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(r_fill))
                w_snap[k*DATA_SIZE +: DATA_SIZE] = r_mem[k];
        end
        if (w_auto_close)
            w_snap[(DEPTH-1)*DATA_SIZE +: DATA_SIZE] = write_data_in;
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_accept && !clear)
            r_mem[r_wr_ptr] <= write_data_in;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            frame_data  <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            frame_data  <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_close) begin
                r_wr_ptr <= '0;
                r_fill   <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_fill   <= r_fill + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_close) begin
                        frame_data  <= w_snap;
                        frame_len   <= w_len;
                        frame_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_close) begin
                        // A new frame only replaces the snapshot if the old one is acked now.
                        if (frame_ack) begin
                            frame_data <= w_snap;
                            frame_len  <= w_len;
                        end else begin
                            overflow   <= 1'b1;
                        end
                    end else if (frame_ack) begin
                        frame_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fill_count = r_fill;
    assign empty      = (r_fill == '0);
    assign full       = (r_fill == CW'(DEPTH));

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, bits per data word.
REQ-002 SHALL have parameter ADDR_SPACE_EXP, default 5, giving DEPTH = 2^ADDR_SPACE_EXP words (32).
REQ-003 SHALL have parameter TERMINATOR, default 8'h0D, the word value that closes a frame.
REQ-004 SHALL have parameter USE_TERMINATOR, default 1; 0 = frames close only when full.
REQ-005 SHALL have port clk_100MHz  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port write_to_fifo  input  1  one-cycle strobe; write_data_in is valid this cycle.
REQ-008 SHALL have port write_data_in  input  DATA_SIZE  incoming word.
REQ-009 SHALL have port clear  input  1  synchronous flush of all state.
REQ-010 SHALL have port frame_ack  input  1  consumer has taken the frame.
REQ-011 SHALL have port frame_data  output  DATA_SIZE*DEPTH  snapshot; word 0 in bits [DATA_SIZE-1:0], word k in bits [(k+1)*DATA_SIZE-1 : k*DATA_SIZE].
REQ-012 SHALL have port frame_len  output  ADDR_SPACE_EXP+1  number of words in the snapshot, range 1..DEPTH.
REQ-013 SHALL have port frame_valid  output  1  snapshot is held and not yet acknowledged.
REQ-014 SHALL have port overflow  output  1  sticky flag: a frame was dropped.
REQ-015 SHALL have port fill_count  output  ADDR_SPACE_EXP+1  words currently in the collection buffer.
REQ-016 SHALL have ports empty and full  output  1 each  fill_count==0 and fill_count==DEPTH respectively.

Function
REQ-017 SHALL keep a collection memory of DEPTH words and a write pointer; an accepted word is stored at the pointer and the pointer increments on the same edge.
REQ-018 SHALL treat write_to_fifo with USE_TERMINATOR=1 and write_data_in==TERMINATOR as a close request; the terminator is not stored and not counted.
REQ-019 SHALL ignore a close request when fill_count==0 (no empty frames).
REQ-020 SHALL close a frame on the edge that stores word number DEPTH (auto-close on full); full is therefore never observed high for more than 0 cycles after that edge.
REQ-021 On close, SHALL copy the collected words into frame_data, zero the unused words k>=len, set frame_len, and reset the write pointer and fill_count to 0, all on the same edge; frame_valid rises on that edge.
REQ-022 SHALL run two states, IDLE (frame_valid=0) and HOLD (frame_valid=1); IDLE->HOLD on close; HOLD->IDLE on frame_ack without a simultaneous close.
REQ-023 In HOLD, collection SHALL continue; frame_data and frame_len SHALL stay stable until ack.
REQ-024 Close in HOLD without frame_ack SHALL drop the new frame (snapshot unchanged), empty the collection buffer, set overflow, and stay in HOLD.
REQ-025 Close in HOLD with frame_ack on the same edge SHALL latch the new frame, keep frame_valid=1, and leave overflow unchanged.
REQ-026 frame_ack in IDLE SHALL have no effect.
REQ-027 clear SHALL take priority over write and ack: pointer, fill_count, frame_len, frame_data, frame_valid, overflow -> 0, state IDLE, and any same-cycle word is discarded.
REQ-028 Latency: a close on edge N SHALL make frame_valid=1 and the new frame_data visible immediately after edge N.

Reset
REQ-029 On reset SHALL force frame_data=0, frame_len=0, frame_valid=0, overflow=0, fill_count=0, empty=1, full=0, state IDLE; memory contents need not be cleared.
REQ-030 Reset asserted mid-collection or in HOLD SHALL discard all data; the first write after release goes to word 0.

Verification
REQ-031 Write 0x41,0x42,0x43,0x0D -> frame_valid=1, frame_len=3, frame_data[23:0]=0x434241, upper bits 0, fill_count=0.
REQ-032 Write 32 words 0x00..0x1F with no terminator -> close on 32nd edge, frame_len=32, word 31=0x1F, frame_valid=1.
REQ-033 Frame "AB\r" held, then "C\r" with no ack -> overflow=1, frame_data still 0x4241, frame_len=2.
REQ-034 Frame held, then ack on the same cycle as the terminator of "XY" -> frame_valid stays 1, frame_len=2, frame_data[15:0]=0x5958, overflow=0.
REQ-035 0x0D as first word -> no frame, fill_count=0; write 0x41,0x42, then assert reset -> all outputs at reset values, next 0x5A,0x0D gives frame_len=1, word 0=0x5A.
REQ-036 clear asserted together with write_to_fifo while frame_valid=1 and overflow=1 -> all outputs 0, empty=1, word discarded.
